// File: rtl/sysid_boot_checker.sv
// Boot-time system-ID / build-timestamp checker: an Avalon-MM read master that reads both words and gates cpu_go.
// Optional macro SYSID_CHECK_RETRY_EN enables per-word retries after a read timeout.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TS    = 32'h65FA_EA53,
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned MAX_RETRY      = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        id_ok,
  output logic        ts_ok,
  output logic        timeout_err,
  output logic        cpu_go,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_ID = 3'd1,
    WT_ID = 3'd2,
    RD_TS = 3'd3,
    WT_TS = 3'd4,
    DONE  = 3'd5,
    FAIL  = 3'd6
  } state_t;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  state_t      state_r, state_nxt_s, tmo_dest_s;
  logic [7:0]  tmo_cnt_r, tmo_cnt_nxt_s;
  logic        done_nxt_s, id_ok_nxt_s, ts_ok_nxt_s, timeout_err_nxt_s;
  logic [31:0] id_value_nxt_s, ts_value_nxt_s;
  logic        retry_ok_s;
  logic        word_ts_s;

`ifdef SYSID_CHECK_RETRY_EN
  localparam logic [7:0] RETRY_LIMIT = 8'(MAX_RETRY);
  logic [7:0] retry_cnt_r, retry_cnt_nxt_s;
  assign retry_ok_s = (retry_cnt_r < RETRY_LIMIT);

  // Per-word retry counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      retry_cnt_r <= 8'd0;
    end else begin
      retry_cnt_r <= retry_cnt_nxt_s;
    end
  end
`else
  // Retries compiled out: every timeout is final.
  assign retry_ok_s = 1'b0 && (MAX_RETRY != 0);
`endif

  assign word_ts_s  = (state_r == RD_TS) || (state_r == WT_TS);
  assign tmo_dest_s = retry_ok_s ? (word_ts_s ? RD_TS : RD_ID) : FAIL;

  // Next-state, timeout and capture logic
  always_comb begin
    state_nxt_s       = state_r;
    tmo_cnt_nxt_s     = tmo_cnt_r;
    done_nxt_s        = done;
    id_ok_nxt_s       = id_ok;
    ts_ok_nxt_s       = ts_ok;
    timeout_err_nxt_s = timeout_err;
    id_value_nxt_s    = id_value;
    ts_value_nxt_s    = ts_value;
`ifdef SYSID_CHECK_RETRY_EN
    retry_cnt_nxt_s   = retry_cnt_r;
`endif
    case (state_r)
      IDLE: begin
        state_nxt_s   = RD_ID;
        tmo_cnt_nxt_s = 8'd0;
      end
      RD_ID, RD_TS: begin
        if (!avm_waitrequest) begin
          state_nxt_s   = word_ts_s ? WT_TS : WT_ID;
          tmo_cnt_nxt_s = 8'd0;
        end else if (tmo_cnt_r == TMO_LIMIT) begin
          state_nxt_s       = tmo_dest_s;
          tmo_cnt_nxt_s     = 8'd0;
          timeout_err_nxt_s = !retry_ok_s;
`ifdef SYSID_CHECK_RETRY_EN
          retry_cnt_nxt_s   = retry_cnt_r + {7'd0, retry_ok_s};
`endif
        end else begin
          tmo_cnt_nxt_s = sat_inc(tmo_cnt_r);
        end
      end
      WT_ID, WT_TS: begin
        // Data arriving on the timeout cycle still counts as a good read.
        if (avm_readdatavalid) begin
          tmo_cnt_nxt_s = 8'd0;
          if (word_ts_s) begin
            ts_value_nxt_s = avm_readdata;
            ts_ok_nxt_s    = (avm_readdata == EXPECTED_TS);
            done_nxt_s     = 1'b1;
            state_nxt_s    = DONE;
          end else begin
            id_value_nxt_s = avm_readdata;
            id_ok_nxt_s    = (avm_readdata == EXPECTED_ID);
            state_nxt_s    = RD_TS;
`ifdef SYSID_CHECK_RETRY_EN
            retry_cnt_nxt_s = 8'd0;
`endif
          end
        end else if (tmo_cnt_r == TMO_LIMIT) begin
          state_nxt_s       = tmo_dest_s;
          tmo_cnt_nxt_s     = 8'd0;
          timeout_err_nxt_s = !retry_ok_s;
`ifdef SYSID_CHECK_RETRY_EN
          retry_cnt_nxt_s   = retry_cnt_r + {7'd0, retry_ok_s};
`endif
        end else begin
          tmo_cnt_nxt_s = sat_inc(tmo_cnt_r);
        end
      end
      DONE, FAIL: begin
        if (start) begin
          state_nxt_s       = RD_ID;
          tmo_cnt_nxt_s     = 8'd0;
          done_nxt_s        = 1'b0;
          id_ok_nxt_s       = 1'b0;
          ts_ok_nxt_s       = 1'b0;
          timeout_err_nxt_s = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
          retry_cnt_nxt_s   = 8'd0;
`endif
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State, counter and registered outputs (bus outputs decoded from the next state)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= IDLE;
      tmo_cnt_r   <= 8'd0;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout_err <= 1'b0;
      cpu_go      <= 1'b0;
      id_value    <= 32'd0;
      ts_value    <= 32'd0;
    end else begin
      state_r     <= state_nxt_s;
      tmo_cnt_r   <= tmo_cnt_nxt_s;
      avm_read    <= (state_nxt_s == RD_ID) || (state_nxt_s == RD_TS);
      avm_address <= (state_nxt_s == RD_TS) || (state_nxt_s == WT_TS);
      busy        <= (state_nxt_s == RD_ID) || (state_nxt_s == WT_ID) ||
                     (state_nxt_s == RD_TS) || (state_nxt_s == WT_TS);
      done        <= done_nxt_s;
      id_ok       <= id_ok_nxt_s;
      ts_ok       <= ts_ok_nxt_s;
      timeout_err <= timeout_err_nxt_s;
      cpu_go      <= done_nxt_s & id_ok_nxt_s & ts_ok_nxt_s;
      id_value    <= id_value_nxt_s;
      ts_value    <= ts_value_nxt_s;
    end
  end

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Directed bench for sysid_boot_checker: pass, mismatch, stall, timeout, reset abort and data-vs-timeout race.
module tb_sysid_boot_checker;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        avm_readdatavalid = 1'b0;
  logic [31:0] avm_readdata = 32'd0;
  logic        avm_address, avm_read, busy, done, id_ok, ts_ok, timeout_err, cpu_go;
  logic [31:0] id_value, ts_value;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'h65FA_EA53;

  int n_checks = 0;
  int n_err = 0;
  int busy_cycles = 0;

  sysid_boot_checker dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .avm_address(avm_address), .avm_read(avm_read), .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout_err(timeout_err),
    .cpu_go(cpu_go), .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (busy) busy_cycles++;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Entered just after the edge that put the DUT in RD_x; leaves it just after the capture edge.
  task automatic do_read(input int waits, input logic [31:0] data, input logic addr);
    for (int i = 0; i < waits; i++) begin
      avm_waitrequest = 1'b1;
      chk("rd_hold", {31'd0, avm_read}, 32'd1);
      chk("addr_hold", {31'd0, avm_address}, {31'd0, addr});
      tick();
    end
    avm_waitrequest = 1'b0;
    chk("rd_req", {31'd0, avm_read}, 32'd1);
    chk("rd_addr", {31'd0, avm_address}, {31'd0, addr});
    tick();
    chk("wt_read_low", {31'd0, avm_read}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = data;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'd0;
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_read", {31'd0, avm_read}, 32'd0);
    chk("rst_cpu_go", {31'd0, cpu_go}, 32'd0);
    chk("rst_tmo", {31'd0, timeout_err}, 32'd0);
    chk("rst_id_value", id_value, 32'd0);

    // Test 1: implicit start, zero-wait slave, matching words
    reset_n = 1'b1;
    busy_cycles = 0;
    tick();
    chk("t1_busy", {31'd0, busy}, 32'd1);
    do_read(0, EXP_ID, 1'b0);
    do_read(0, EXP_TS, 1'b1);
    chk("t1_done", {31'd0, done}, 32'd1);
    chk("t1_id_ok", {31'd0, id_ok}, 32'd1);
    chk("t1_ts_ok", {31'd0, ts_ok}, 32'd1);
    chk("t1_cpu_go", {31'd0, cpu_go}, 32'd1);
    chk("t1_busy_end", {31'd0, busy}, 32'd0);
    chk("t1_busy_cycles", busy_cycles, 32'd4);
    chk("t1_ts_value", ts_value, EXP_TS);

    // Test 2: timestamp mismatch
    pulse_start();
    chk("t2_done_clr", {31'd0, done}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd1);
    do_read(0, EXP_ID, 1'b0);
    do_read(0, 32'h1234_5678, 1'b1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_id_ok", {31'd0, id_ok}, 32'd1);
    chk("t2_ts_ok", {31'd0, ts_ok}, 32'd0);
    chk("t2_cpu_go", {31'd0, cpu_go}, 32'd0);
    chk("t2_ts_value", ts_value, 32'h1234_5678);

    // Test 3: 5-cycle waitrequest stall on the ID read
    pulse_start();
    do_read(5, EXP_ID, 1'b0);
    do_read(0, EXP_TS, 1'b1);
    chk("t3_cpu_go", {31'd0, cpu_go}, 32'd1);
    chk("t3_ts_value", ts_value, EXP_TS);

    // Test 5: start ignored while busy, then reset during WT_TS
    pulse_start();
    avm_waitrequest = 1'b0;
    tick();
    pulse_start();
    chk("t5_busy_ign", {31'd0, busy}, 32'd1);
    chk("t5_wt_read", {31'd0, avm_read}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = EXP_ID;
    tick();
    avm_readdatavalid = 1'b0;
    chk("t5_rd_ts_addr", {31'd0, avm_address}, 32'd1);
    chk("t5_rd_ts_read", {31'd0, avm_read}, 32'd1);
    tick();
    #1 reset_n = 1'b0;
    #1;
    chk("t5_rst_busy", {31'd0, busy}, 32'd0);
    chk("t5_rst_read", {31'd0, avm_read}, 32'd0);
    chk("t5_rst_ts_value", ts_value, 32'd0);
    chk("t5_rst_done", {31'd0, done}, 32'd0);
    tick();
    reset_n = 1'b1;
    busy_cycles = 0;
    tick();
    do_read(0, EXP_ID, 1'b0);
    do_read(0, EXP_TS, 1'b1);
    chk("t5_recheck_go", {31'd0, cpu_go}, 32'd1);
    chk("t5_busy_cycles", busy_cycles, 32'd4);
    pulse_start();
    do_read(0, EXP_ID, 1'b0);
    do_read(0, EXP_TS, 1'b1);
    chk("t5_restart_go", {31'd0, cpu_go}, 32'd1);

    // Test 6: readdatavalid on the cycle the counter reaches the limit
    pulse_start();
    avm_waitrequest = 1'b0;
    tick();
    repeat (16) tick();
    chk("t6_busy", {31'd0, busy}, 32'd1);
    chk("t6_no_tmo_yet", {31'd0, timeout_err}, 32'd0);
    avm_readdatavalid = 1'b1;
    avm_readdata = EXP_ID;
    tick();
    avm_readdatavalid = 1'b0;
    chk("t6_tmo", {31'd0, timeout_err}, 32'd0);
    chk("t6_next_addr", {31'd0, avm_address}, 32'd1);
    do_read(0, EXP_TS, 1'b1);
    chk("t6_done", {31'd0, done}, 32'd1);
    chk("t6_cpu_go", {31'd0, cpu_go}, 32'd1);

    // Test 4: slave never returns data
    pulse_start();
    avm_waitrequest = 1'b0;
`ifdef SYSID_CHECK_RETRY_EN
    for (int a = 0; a < 4; a++) begin
      chk("t4_attempt_read", {31'd0, avm_read}, 32'd1);
      tick();
      repeat (16) tick();
      chk("t4_attempt_busy", {31'd0, busy}, 32'd1);
      tick();
      if (a < 3) chk("t4_retry_read", {31'd0, avm_read}, 32'd1);
      else chk("t4_final_tmo", {31'd0, timeout_err}, 32'd1);
    end
`else
    tick();
    repeat (16) tick();
    chk("t4_busy_pre", {31'd0, busy}, 32'd1);
    chk("t4_tmo_pre", {31'd0, timeout_err}, 32'd0);
    tick();
`endif
    chk("t4_tmo", {31'd0, timeout_err}, 32'd1);
    chk("t4_busy", {31'd0, busy}, 32'd0);
    chk("t4_done", {31'd0, done}, 32'd0);
    chk("t4_cpu_go", {31'd0, cpu_go}, 32'd0);
    chk("t4_read", {31'd0, avm_read}, 32'd0);

    // Unsolicited data in FAIL is ignored
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'hDEAD_BEEF;
    tick();
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'd0;
    chk("unsol_id_value", id_value, EXP_ID);
    chk("unsol_tmo_hold", {31'd0, timeout_err}, 32'd1);

    // Start from FAIL clears the error and re-runs
    pulse_start();
    chk("recover_tmo_clr", {31'd0, timeout_err}, 32'd0);
    do_read(0, EXP_ID, 1'b0);
    do_read(0, EXP_TS, 1'b1);
    chk("recover_cpu_go", {31'd0, cpu_go}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
